// File: rtl/display_arbiter.sv
// display_arbiter
//
// Round-robin scheduler that shares one 32-bit display word between up to
// four requesters. Each grant lasts DWELL cycles unless `lock` freezes the
// dwell counter or the grantee withdraws its request. A `done` pulse marks
// each normally completed dwell period.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   req           per-requester request, level-sensitive
//   data_in       requester i word at [32i+31:32i]
//   lock          freezes the dwell counter and holds the current grant
//   data_display  registered word of the grantee (1-cycle latency)
//   grant         one-hot grant, zero when idle
//   grant_id      index of the grantee, holds last value when idle
//   valid         high whenever grant is non-zero
//   done          one-cycle pulse on bit g when g's dwell completes normally

module display_arbiter #(
   parameter int NREQ  = 4,
   parameter int DWELL = 50_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   data_in,
   input  logic                 lock,
   output logic [31:0]          data_display,
   output logic [NREQ-1:0]      grant,
   output logic [1:0]           grant_id,
   output logic                 valid,
   output logic [NREQ-1:0]      done
);

   localparam int CW = $clog2(DWELL);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [1:0]      ptr;

   logic [31:0]     words [NREQ];
   logic [1:0]      win;
   logic [NREQ-1:0] win_onehot;
   logic            any_req;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_words
         assign words[gi] = data_in[32*gi +: 32];
      end
   endgenerate

   assign any_req = |req;

   // Scan from ptr+1 upward with wrap-around so the previous owner is the
   // last candidate. Only meaningful when any_req is high.
   always_comb begin
      logic found;
      int   idx;
      win   = ptr;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            win   = 2'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      win_onehot      = '0;
      win_onehot[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         grant_id     <= '0;
         valid        <= 1'b0;
         data_display <= '0;
         done         <= '0;
         cnt          <= '0;
         ptr          <= '0;
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state        <= SHOW;
                  grant        <= win_onehot;
                  grant_id     <= win;
                  valid        <= 1'b1;
                  ptr          <= win;
                  cnt          <= CW'(DWELL - 1);
                  data_display <= words[win];
               end
            end
            SHOW: begin
               if (!req[grant_id]) begin
                  // Abort: grantee withdrew. ptr already equals grant_id, so
                  // the scan below naturally starts after the aborted owner.
                  if (any_req) begin
                     grant        <= win_onehot;
                     grant_id     <= win;
                     ptr          <= win;
                     cnt          <= CW'(DWELL - 1);
                     data_display <= words[win];
                  end else begin
                     state <= IDLE;
                     grant <= '0;
                     valid <= 1'b0;
                  end
               end else if (cnt == '0 && !lock) begin
                  // Normal completion; req[grant_id] is set, so a winner
                  // always exists (possibly the same requester again).
                  done[grant_id] <= 1'b1;
                  grant          <= win_onehot;
                  grant_id       <= win;
                  ptr            <= win;
                  cnt            <= CW'(DWELL - 1);
                  data_display   <= words[win];
               end else begin
                  data_display <= words[grant_id];
                  if (!lock) begin
                     cnt <= cnt - CW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter (NREQ=4, DWELL=4): directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_display_arbiter;

   localparam int NREQ  = 4;
   localparam int DWELL = 4;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req;
   logic [127:0]  data_in;
   logic          lock;
   logic [31:0]   data_display;
   logic [3:0]    grant;
   logic [1:0]    grant_id;
   logic          valid;
   logic [3:0]    done;

   display_arbiter #(.NREQ(NREQ), .DWELL(DWELL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .data_in      (data_in),
      .lock         (lock),
      .data_display (data_display),
      .grant        (grant),
      .grant_id     (grant_id),
      .valid        (valid),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] din [4];

   // Reference model: owner (-1 = idle), cycles served so far, last owner.
   int          m_owner;
   int          m_served;
   int          m_ptr;
   logic [3:0]  m_grant;
   logic [1:0]  m_gid;
   logic        m_valid;
   logic [31:0] m_disp;
   logic [3:0]  m_done;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner  = -1;
      m_served = 0;
      m_ptr    = 0;
      m_grant  = '0;
      m_gid    = '0;
      m_valid  = 1'b0;
      m_disp   = '0;
      m_done   = '0;
   endtask

   task automatic model_grant(input int w);
      m_owner  = w;
      m_ptr    = w;
      m_served = 0;
      m_grant  = 4'(1 << w);
      m_gid    = 2'(w);
      m_valid  = 1'b1;
      m_disp   = din[w];
   endtask

   // One rising edge worth of behaviour, from the inputs present at the edge.
   task automatic model_edge(input logic [3:0] r, input logic l);
      int w;
      m_done = '0;
      w = pick(r, m_ptr);
      if (m_owner < 0) begin
         if (w >= 0) model_grant(w);
      end else if (!r[m_owner]) begin
         m_ptr = m_owner;
         w = pick(r, m_ptr);
         if (w >= 0) model_grant(w);
         else begin
            m_owner = -1;
            m_grant = '0;
            m_valid = 1'b0;
         end
      end else if (m_served == DWELL - 1 && !l) begin
         m_done[m_owner] = 1'b1;
         model_grant(w);
      end else begin
         m_disp = din[m_owner];
         if (!l) m_served++;
      end
   endtask

   task automatic compare_all(input string ph);
      check({ph, ".grant"},    32'(grant),    32'(m_grant));
      check({ph, ".grant_id"}, 32'(grant_id), 32'(m_gid));
      check({ph, ".valid"},    32'(valid),    32'(m_valid));
      check({ph, ".display"},  data_display,  m_disp);
      check({ph, ".done"},     32'(done),     32'(m_done));
   endtask

   // Drive at the falling edge, model the rising edge, check at the next fall.
   task automatic step(input string ph, input logic [3:0] r, input logic l);
      req     = r;
      lock    = l;
      data_in = {din[3], din[2], din[1], din[0]};
      @(posedge clk);
      model_edge(r, l);
      @(negedge clk);
      compare_all(ph);
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic async_reset(input string ph);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all(ph);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] r;
      logic       l;
      rst_n = 1'b0;
      req   = '0;
      lock  = 1'b0;
      for (int i = 0; i < 4; i++) din[i] = '0;
      data_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all("reset");
      rst_n = 1'b1;
      repeat (3) step("idle", 4'b0000, 1'b0);

      // Single requester: continuous re-grant with done every DWELL cycles.
      din[0] = 32'h1234_5678;
      repeat (13) step("single", 4'b0001, 1'b0);
      async_reset("arst_show");

      // Round-robin over 1011 with live data on requester 1.
      din[0] = 32'h0000_00A0;
      din[3] = 32'h0000_00D3;
      for (int c = 0; c < 17; c++) begin
         din[1] = 32'hAAAA_0000 | 32'(c & 1);
         step("rr", 4'b1011, 1'b0);
      end

      // Lock asserted when the dwell counter would be at 2.
      for (int c = 0; c < 8 && m_served != 1; c++) step("lock_wait", 4'b1011, 1'b0);
      check("lock_reach", 32'(m_served), 32'd1);
      repeat (10) step("lock_hold", 4'b1011, 1'b1);
      repeat (6) step("lock_rel", 4'b1011, 1'b0);
      async_reset("arst_lock");

      // Abort: requester 2 withdraws in its second dwell cycle.
      din[0] = 32'h0000_0C00;
      din[2] = 32'h0000_0C02;
      step("abort_g2", 4'b0100, 1'b0);
      step("abort_g2b", 4'b0101, 1'b0);
      repeat (4) step("abort", 4'b0001, 1'b0);
      step("abort_idle", 4'b0000, 1'b0);

      // Randomized traffic with sticky requests and lock.
      r = 4'b0000;
      l = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 5) == 0) r = 4'($urandom);
         if ($urandom_range(0, 9) == 0) l = ~l;
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 2) == 0) din[i] = $urandom;
         end
         step("rand", r, l);
         if (c == 200) async_reset("arst_rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
